// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I datapath (add, addi, lw, sw,
// beq, jal). Drives the 2-bit ALUop consumed by ALU_control plus every
// datapath enable and mux select. Memory accesses wait on mem_ready.
module multicycle_control #(
  parameter logic [6:0] OPC_R   = 7'b0110011,
  parameter logic [6:0] OPC_I   = 7'b0010011,
  parameter logic [6:0] OPC_LW  = 7'b0000011,
  parameter logic [6:0] OPC_SW  = 7'b0100011,
  parameter logic [6:0] OPC_BEQ = 7'b1100011,
  parameter logic [6:0] OPC_JAL = 7'b1101111
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic [3:0] state_o,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_IF       = 4'd1,
    S_ID       = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EX_R     = 4'd7,
    S_EX_I     = 4'd8,
    S_ALU_WB   = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   illegal_q;
  logic   bad_opcode;

  // State register; reset aborts any in-flight instruction immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Sticky illegal flag, set on the edge that leaves ID with a bad opcode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      illegal_q <= 1'b0;
    end else if (bad_opcode) begin
      illegal_q <= 1'b1;
    end
  end

  // Next-state and output decode; every output defaults to 0 each state.
  always_comb begin
    state_d     = S_IF;
    bad_opcode  = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;

    case (state_q)
      S_INIT: begin
        state_d = S_IF;
      end

      S_IF: begin
        // PC+4 is computed while the fetch is outstanding; PC and IR load
        // together on the cycle memory answers.
        MemRead  = 1'b1;
        IorD     = 1'b0;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b01;
        ALUop    = 2'b00;
        PCSource = 2'b00;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
        state_d  = mem_ready ? S_ID : S_IF;
      end

      S_ID: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b11;
        ALUop   = 2'b00;
        if (opcode == OPC_LW || opcode == OPC_SW) begin
          state_d = S_MEM_ADDR;
        end else if (opcode == OPC_R) begin
          state_d = S_EX_R;
        end else if (opcode == OPC_I) begin
          state_d = S_EX_I;
        end else if (opcode == OPC_BEQ) begin
          state_d = S_BEQ;
        end else if (opcode == OPC_JAL) begin
          state_d = S_JAL;
        end else begin
          bad_opcode = 1'b1;
          instr_done = 1'b1;
          state_d    = S_IF;
        end
      end

      S_MEM_ADDR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUop   = 2'b00;
        // IR is stable here, so the opcode can be sampled again.
        if (opcode == OPC_LW) begin
          state_d = S_MEM_RD;
        end else if (opcode == OPC_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_IF;
        end
      end

      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      end

      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b01;
        instr_done = 1'b1;
        state_d    = S_IF;
      end

      S_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_IF : S_MEM_WR;
      end

      S_EX_R: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b00;
        ALUop   = 2'b10;
        state_d = S_ALU_WB;
      end

      S_EX_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUop   = 2'b10;
        state_d = S_ALU_WB;
      end

      S_ALU_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b00;
        instr_done = 1'b1;
        state_d    = S_IF;
      end

      S_BEQ: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b00;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
        state_d     = S_IF;
      end

      S_JAL: begin
        // The register file captures the current PC (already PC+4) as the
        // link value on the same edge that PC takes the target in ALUOut.
        RegWrite   = 1'b1;
        MemtoReg   = 2'b10;
        PCWrite    = 1'b1;
        PCSource   = 2'b01;
        instr_done = 1'b1;
        state_d    = S_JAL == state_q ? S_IF : S_IF;
      end

      default: begin
        // Unused codes recover to fetch with every output held low.
        state_d = S_IF;
      end
    endcase
  end

  assign state_o = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each supported instruction,
// memory stalls, an illegal opcode, and reset during a pending store.
module tb_multicycle_control;

  logic       clk;
  logic       rstn;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] MemtoReg, ALUSrcA, ALUSrcB, ALUop, PCSource;
  logic [3:0] state_o;
  logic       instr_done, illegal;

  int checks   = 0;
  int failures = 0;

  multicycle_control dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource),
    .state_o(state_o), .instr_done(instr_done), .illegal(illegal)
  );

  // Bundle order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite RegWrite
  //               MemtoReg[2] ALUSrcA[2] ALUSrcB[2] ALUop[2] PCSource[2] instr_done
  logic [17:0] outs;
  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUop, PCSource,
                 instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, then let combinational outputs settle.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rstn      = 1'b0;
    opcode    = 7'b0000000;
    mem_ready = 1'b1;

    // Reset held: INIT with all outputs low.
    repeat (2) nxt();
    chk("rst_state", state_o, 0);
    chk("rst_outs", outs, 0);
    chk("rst_illegal", illegal, 0);
    rstn = 1'b1;
    #1;
    chk("rel_state0", state_o, 0);

    // add: 1,2,7,9 then IF.
    opcode = 7'b0110011;
    nxt();
    chk("add_if_state", state_o, 1);
    // IF with mem_ready=1: PCWrite IRWrite MemRead, ALUSrcB=01.
    chk("add_if_outs", outs, 18'b1_0_0_1_0_1_0_00_00_01_00_00_0);
    nxt();
    chk("add_id_state", state_o, 2);
    chk("add_id_outs", outs, 18'b0_0_0_0_0_0_0_00_00_11_00_00_0);
    nxt();
    chk("add_ex_state", state_o, 7);
    chk("add_ex_aluop", ALUop, 2'b10);
    chk("add_ex_regwrite", RegWrite, 0);
    chk("add_ex_done", instr_done, 0);
    nxt();
    chk("add_wb_state", state_o, 9);
    chk("add_wb_outs", outs, 18'b0_0_0_0_0_0_1_00_00_00_00_00_1);
    nxt();
    chk("add_back_if", state_o, 1);

    // IF stall: mem_ready low holds IF and suppresses the loads.
    opcode    = 7'b0000011;
    mem_ready = 1'b0;
    #1;
    chk("ifstall_irwrite", IRWrite, 0);
    chk("ifstall_pcwrite", PCWrite, 0);
    chk("ifstall_memread", MemRead, 1);
    nxt();
    chk("ifstall_state", state_o, 1);
    mem_ready = 1'b1;
    #1;
    chk("ifstall_release_ir", IRWrite, 1);

    // lw with two stall cycles in MEM_RD: 2,3,4,4,4,5.
    nxt();
    chk("lw_id", state_o, 2);
    nxt();
    chk("lw_addr_state", state_o, 3);
    chk("lw_addr_outs", outs, 18'b0_0_0_0_0_0_0_00_01_10_00_00_0);
    nxt();
    mem_ready = 1'b0;
    #1;
    chk("lw_rd_state_a", state_o, 4);
    chk("lw_rd_mr_a", {MemRead, IorD, MemWrite}, 3'b110);
    nxt();
    chk("lw_rd_state_b", state_o, 4);
    chk("lw_rd_mr_b", {MemRead, IorD, MemWrite}, 3'b110);
    nxt();
    mem_ready = 1'b1;
    #1;
    chk("lw_rd_state_c", state_o, 4);
    chk("lw_rd_mr_c", {MemRead, IorD}, 2'b11);
    nxt();
    chk("lw_wb_state", state_o, 5);
    chk("lw_wb_outs", outs, 18'b0_0_0_0_0_0_1_01_00_00_00_00_1);
    nxt();
    chk("lw_back_if", state_o, 1);

    // sw with mem_ready=1: 1,2,3,6 then IF.
    opcode = 7'b0100011;
    nxt();
    nxt();
    chk("sw_addr", state_o, 3);
    nxt();
    chk("sw_wr_state", state_o, 6);
    chk("sw_wr_outs", outs, 18'b0_0_1_0_1_0_0_00_00_00_00_00_1);
    nxt();
    chk("sw_back_if", state_o, 1);

    // beq: 1,2,10 then IF.
    opcode = 7'b1100011;
    nxt();
    nxt();
    chk("beq_state", state_o, 10);
    chk("beq_outs", outs, 18'b0_1_0_0_0_0_0_00_01_00_01_01_1);
    nxt();
    chk("beq_back_if", state_o, 1);

    // jal: 1,2,11 then IF.
    opcode = 7'b1101111;
    nxt();
    nxt();
    chk("jal_state", state_o, 11);
    chk("jal_outs", outs, 18'b1_0_0_0_0_0_1_10_00_00_00_01_1);
    nxt();
    chk("jal_back_if", state_o, 1);

    // addi: 1,2,8,9.
    opcode = 7'b0010011;
    nxt();
    nxt();
    chk("addi_ex_state", state_o, 8);
    chk("addi_ex_outs", outs, 18'b0_0_0_0_0_0_0_00_01_10_10_00_0);
    nxt();
    chk("addi_wb_state", state_o, 9);
    nxt();
    chk("addi_back_if", state_o, 1);
    chk("illegal_still_0", illegal, 0);

    // Illegal opcode: 1,2,1 with instr_done in ID, sticky flag afterwards.
    opcode = 7'b1111111;
    nxt();
    chk("ill_id_state", state_o, 2);
    chk("ill_id_done", instr_done, 1);
    chk("ill_id_flag", illegal, 0);
    nxt();
    chk("ill_back_if", state_o, 1);
    chk("ill_set", illegal, 1);
    opcode = 7'b0110011;
    repeat (4) nxt();
    chk("ill_sticky_state", state_o, 1);
    chk("ill_sticky", illegal, 1);

    // Reset asserted while a store waits in MEM_WR.
    opcode = 7'b0100011;
    nxt();
    nxt();
    mem_ready = 1'b0;
    nxt();
    chk("rstwr_state", state_o, 6);
    chk("rstwr_memwrite", MemWrite, 1);
    chk("rstwr_done", instr_done, 0);
    rstn = 1'b0;
    #1;
    chk("rstwr_mw_drop", MemWrite, 0);
    chk("rstwr_state0", state_o, 0);
    chk("rstwr_outs", outs, 0);
    chk("rstwr_illegal_clr", illegal, 0);
    nxt();
    rstn      = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rstwr_rel_state0", state_o, 0);
    nxt();
    chk("rstwr_rel_if", state_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I datapath.
- Sits directly upstream of ALU_control: drives its 2-bit ALUop and all datapath enables/mux selects for one instruction per 3–5 states.
- Subset: add, addi, lw, sw, beq, jal.
- Memory accesses use a ready handshake, so instruction/data fetches can stall.

Parameters:
- OPC_R, 7'b0110011, R-type (add)
- OPC_I, 7'b0010011, addi
- OPC_LW, 7'b0000011, load word
- OPC_SW, 7'b0100011, store word
- OPC_BEQ, 7'b1100011, branch equal
- OPC_JAL, 7'b1101111, jump and link

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]; valid from ID state onward
- mem_ready  in  1  memory completed the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- RegWrite  out  1  register file write
- MemtoReg  out  2  wb source: 00=ALUOut, 01=MDR, 10=PC
- ALUSrcA  out  2  00=PC, 01=rs1
- ALUSrcB  out  2  00=rs2, 01=const 4, 10=imm, 11=imm
- ALUop  out  2  to ALU_control: 00=add, 01=sub (beq), 10=funct-decoded
- PCSource  out  2  00=ALU result, 01=ALUOut
- state_o  out  4  current state code, debug
- instr_done  out  1  last cycle of current instruction
- illegal  out  1  sticky; unsupported opcode seen

Behaviour:
- State register resets asynchronously to INIT(0) on rstn=0. Rstn low mid-instruction aborts immediately: no pending write completes.
- All outputs are decoded from state (plus mem_ready where noted). Any output not listed for a state is 0. In INIT every output is 0 and illegal is 0.
- INIT(0) -> IF unconditionally.
- IF(1):
  - MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay in IF while mem_ready=0; go to ID when mem_ready=1.
- ID(2): ALUSrcA=00, ALUSrcB=11, ALUop=00 (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEM_ADDR
  - R -> EX_R
  - I -> EX_I
  - BEQ -> BEQ
  - JAL -> JAL
  - anything else -> IF, with illegal set on the next edge and instr_done=1 this cycle.
- MEM_ADDR(3): ALUSrcA=01, ALUSrcB=10, ALUop=00. Next: LW -> MEM_RD, SW -> MEM_WR (opcode re-sampled; IR is stable).
- MEM_RD(4): MemRead=1, IorD=1. Hold until mem_ready=1, then -> MEM_WB.
- MEM_WB(5): RegWrite=1, MemtoReg=01, instr_done=1. -> IF.
- MEM_WR(6): MemWrite=1, IorD=1, instr_done=mem_ready. Hold until mem_ready=1, then -> IF.
- EX_R(7): ALUSrcA=01, ALUSrcB=00, ALUop=10. -> ALU_WB.
- EX_I(8): ALUSrcA=01, ALUSrcB=10, ALUop=10. -> ALU_WB.
- ALU_WB(9): RegWrite=1, MemtoReg=00, instr_done=1. -> IF.
- BEQ(10): ALUSrcA=01, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, instr_done=1. -> IF.
- JAL(11): RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=01, instr_done=1. -> IF.
  - Register file samples the old PC value (already PC+4) on the same edge that PC loads the target.
- Codes 12–15 are unreachable. If entered, go to IF next cycle with all outputs 0.
- illegal is a sticky register: set on any illegal decode, cleared only by rstn.
- Latency with mem_ready tied to 1:
  - add/addi 4 cycles, lw 5, sw 4, beq 3, jal 3, illegal 2.
  - Each mem_ready=0 cycle adds one cycle.
- MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.

Test Plan:
- Reset: hold rstn=0 -> state_o=0, all outputs 0. Release -> state_o 0,1 on consecutive edges.
- add, mem_ready=1 -> states 1,2,7,9. ALUop=10 in EX_R. RegWrite=1 and instr_done=1 only in state 9. Back to IF on cycle 5.
- lw with mem_ready low 2 cycles in MEM_RD -> states 1,2,3,4,4,4,5. MemRead=IorD=1 throughout state 4. MemtoReg=01 in state 5.
- beq -> states 1,2,10. ALUop=01, PCWriteCond=1, PCSource=01 in state 10. Then IF.
- opcode 7'b1111111 -> states 1,2,1. instr_done=1 in ID. illegal=1 from the next edge and stays 1 until rstn=0.
- rstn pulsed low during MEM_WR while mem_ready=0 -> MemWrite drops to 0 immediately. state_o=0, then IF after release.
